// File: rtl/data_mem_responder.sv
// LSU data-port memory slave: word RAM with byte-enable writes and an address
// window, configurable grant delay, response latency and in-flight limit.
module data_mem_responder #(
  parameter int unsigned        DATA_W     = 32,
  parameter int unsigned        ADDR_W     = 32,
  parameter int unsigned        DEPTH      = 1024,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = 'h0010_0000,
  parameter int unsigned        GNT_DELAY  = 0,
  parameter int unsigned        RESP_DELAY = 1,
  parameter int unsigned        MAX_OUTST  = 2,
  localparam int unsigned       BE_W       = DATA_W / 8,
  localparam int unsigned       OUT_W      = $clog2(MAX_OUTST) + 1
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              data_req_i,
  output logic              data_gnt_o,
  input  logic              data_we_i,
  input  logic [BE_W-1:0]   data_be_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_rvalid_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_err_o,
  input  logic              gnt_stall_i,
  output logic [OUT_W-1:0]  outstanding_o
);

  localparam int unsigned      OFF_W = $clog2(BE_W);
  localparam int unsigned      IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]  LIMIT = {1'b0, BASE_ADDR} + (ADDR_W+1)'(DEPTH * BE_W);

  logic              accept;
  logic              eligible;
  logic              in_range;
  logic [IDX_W-1:0]  word_idx;
  logic [OUT_W-1:0]  outst_q;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [RESP_DELAY-1:0]             vld_pipe;
  logic [RESP_DELAY-1:0]             err_pipe;
  logic [RESP_DELAY-1:0][DATA_W-1:0] rdata_pipe;

  // a retiring response only frees its slot once outst_q has counted it down
  assign eligible = (outst_q < OUT_W'(MAX_OUTST)) && !gnt_stall_i;
  assign accept   = data_req_i && data_gnt_o;

  assign in_range = ({1'b0, data_addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, data_addr_i} < LIMIT);
  assign word_idx = IDX_W'((data_addr_i - BASE_ADDR) >> OFF_W);

  generate
    if (GNT_DELAY == 0) begin : g_gnt_comb
      assign data_gnt_o = rst_ni && data_req_i && eligible;
    end else begin : g_gnt_fsm
      localparam int unsigned CNT_W = $clog2(GNT_DELAY + 1);
      typedef enum logic [1:0] {IDLE, WAIT, GNT} gstate_e;
      gstate_e          state_q;
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          case (state_q)
            IDLE: if (data_req_i) begin
              cnt_q   <= CNT_W'(1);
              state_q <= (GNT_DELAY == 1) ? GNT : WAIT;
            end
            WAIT: if (!data_req_i) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (!gnt_stall_i) begin
              cnt_q <= cnt_q + 1'b1;
              if (cnt_q + 1 == GNT_DELAY) state_q <= GNT;
            end
            GNT: if (!data_req_i || accept) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
            default: begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          endcase
        end
      end

      assign data_gnt_o = (state_q == GNT) && eligible;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (accept && data_we_i && in_range) begin
      for (int b = 0; b < BE_W; b++)
        if (data_be_i[b]) mem[word_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
    end
  end

  // read data is captured at the accept edge so later writes cannot alter it
  assign resp_rdata = (accept && !data_we_i && in_range) ? mem[word_idx] : '0;
  assign resp_err   = accept && !in_range;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe   <= '0;
      err_pipe   <= '0;
      rdata_pipe <= '0;
    end else begin
      vld_pipe[0]   <= accept;
      err_pipe[0]   <= resp_err;
      rdata_pipe[0] <= resp_rdata;
      for (int i = 1; i < RESP_DELAY; i++) begin
        vld_pipe[i]   <= vld_pipe[i-1];
        err_pipe[i]   <= err_pipe[i-1];
        rdata_pipe[i] <= rdata_pipe[i-1];
      end
    end
  end

  assign data_rvalid_o = vld_pipe[RESP_DELAY-1];
  assign data_err_o    = err_pipe[RESP_DELAY-1];
  assign data_rdata_o  = rdata_pipe[RESP_DELAY-1];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) outst_q <= '0;
    else         outst_q <= outst_q + OUT_W'(accept) - OUT_W'(data_rvalid_o);
  end

  assign outstanding_o = outst_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: random traffic against a transaction-level model
// (instance a) plus directed grant-delay and memory checks (instance b).
module tb_data_mem_responder;

  localparam logic [31:0] BASE = 32'h0010_0000;
  localparam int          A_RD = 3;
  localparam int          A_MO = 2;

  logic clk = 0;
  logic rst_ni = 0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // instance a: combinational grant, 3-cycle response, 2 in flight
  logic        a_req = 0, a_we = 0, a_stall = 0;
  logic [3:0]  a_be = 0;
  logic [31:0] a_addr = 0, a_wdata = 0;
  logic        a_gnt, a_rvalid, a_err;
  logic [31:0] a_rdata;
  logic [1:0]  a_outst;

  data_mem_responder #(.GNT_DELAY(0), .RESP_DELAY(A_RD), .MAX_OUTST(A_MO)) u_a (
    .clk(clk), .rst_ni(rst_ni), .data_req_i(a_req), .data_gnt_o(a_gnt),
    .data_we_i(a_we), .data_be_i(a_be), .data_addr_i(a_addr), .data_wdata_i(a_wdata),
    .data_rvalid_o(a_rvalid), .data_rdata_o(a_rdata), .data_err_o(a_err),
    .gnt_stall_i(a_stall), .outstanding_o(a_outst)
  );

  // instance b: 2-cycle grant delay, 1-cycle response
  logic        b_req = 0, b_we = 0, b_stall = 0;
  logic [3:0]  b_be = 0;
  logic [31:0] b_addr = 0, b_wdata = 0;
  logic        b_gnt, b_rvalid, b_err;
  logic [31:0] b_rdata;
  logic [1:0]  b_outst;

  data_mem_responder #(.GNT_DELAY(2), .RESP_DELAY(1), .MAX_OUTST(2)) u_b (
    .clk(clk), .rst_ni(rst_ni), .data_req_i(b_req), .data_gnt_o(b_gnt),
    .data_we_i(b_we), .data_be_i(b_be), .data_addr_i(b_addr), .data_wdata_i(b_wdata),
    .data_rvalid_o(b_rvalid), .data_rdata_o(b_rdata), .data_err_o(b_err),
    .gnt_stall_i(b_stall), .outstanding_o(b_outst)
  );

  // reference model for instance a: in-order queue of pending responses
  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t       q[$];
  logic [31:0] amem [0:1023];
  int          cyc = 0;
  bit          last_acc;

  task automatic a_model_access(input bit we, input logic [3:0] be, input logic [31:0] addr,
                                input logic [31:0] wd);
    resp_t       r;
    longint      a;
    int          idx;
    a = longint'(addr);
    r.due = cyc + A_RD;
    r.rdata = 0;
    r.err = 0;
    if (a < longint'(BASE) || a >= longint'(BASE) + 4096) begin
      r.err = 1;
    end else begin
      idx = int'((a - longint'(BASE)) / 4);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) amem[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        r.rdata = amem[idx];
      end
    end
    q.push_back(r);
  endtask

  // one cycle on instance a: drive, compare, advance the model to the next edge
  task automatic a_step(input bit rq, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd, input bit st);
    bit          exp_gnt, exp_rv;
    logic [31:0] exp_rd;
    logic        exp_err;
    a_req = rq; a_we = we; a_be = be; a_addr = addr; a_wdata = wd; a_stall = st;
    #1;
    exp_gnt = rq && (q.size() < A_MO) && !st;
    exp_rv  = 0;
    exp_rd  = 0;
    exp_err = 0;
    if (q.size() > 0) begin
      if (q[0].due == cyc) begin
        exp_rv  = 1;
        exp_rd  = q[0].rdata;
        exp_err = q[0].err;
      end
    end
    chk("a_gnt", a_gnt, exp_gnt);
    chk("a_rvalid", a_rvalid, exp_rv);
    chk("a_rdata", a_rdata, exp_rd);
    chk("a_err", a_err, exp_err);
    chk("a_outst", a_outst, q.size());
    if (exp_rv) void'(q.pop_front());
    if (exp_gnt) a_model_access(we, be, addr, wd);
    last_acc = exp_gnt;
    @(negedge clk);
    cyc++;
  endtask

  task automatic a_do(input bit we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wd);
    int n = 0;
    last_acc = 0;
    while (!last_acc && n < 10) begin
      a_step(1, we, be, addr, wd, 0);
      n++;
    end
    if (!last_acc) chk("a_do_timeout", 1, 0);
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0: return BASE - 4;
      1: return BASE + 4096;
      2: return BASE + 4092 + $urandom_range(0, 3);
      3: return $urandom;
      default: return BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
    endcase
  endfunction

  // one transfer on instance b; counts cycles from req to gnt and checks the response
  task automatic b_xfer(input bit we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input int stall_cyc, input int exp_wait,
                        input logic [31:0] exp_rd, input logic exp_err);
    int w = 0;
    bit got = 0;
    b_req = 1; b_we = we; b_addr = addr; b_be = be; b_wdata = wd;
    while (!got && w < 20) begin
      b_stall = (w == stall_cyc);
      #1;
      if (b_gnt) got = 1;
      else begin
        @(negedge clk);
        w++;
      end
    end
    chk("b_wait", w, exp_wait);
    @(negedge clk);
    b_req = 0; b_stall = 0;
    #1;
    chk("b_rvalid", b_rvalid, got);
    chk("b_rdata", b_rdata, got ? exp_rd : 32'h0);
    chk("b_err", b_err, got ? exp_err : 1'b0);
    @(negedge clk);
    #1;
    chk("b_rvalid_one", b_rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int g [3];
    int ng;
    bit hold, rq, we, st;
    logic [3:0]  be;
    logic [31:0] addr, wd;

    // reset: outputs low and gnt held low even with req asserted
    a_req = 1; b_req = 1;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_a_outst", a_outst, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_b_err", b_err, 0);
    a_req = 0; b_req = 0;
    @(negedge clk);
    rst_ni = 1;

    // instance a: prefill the words random traffic can read
    for (int i = 0; i < 16; i++) a_do(1, 4'hF, BASE + 4 * i, $urandom);
    a_do(1, 4'hF, BASE + 4092, $urandom);

    // instance a: random traffic, request fields held until granted
    hold = 0;
    rq = 0; we = 0; be = 0; addr = 0; wd = 0;
    for (int n = 0; n < 500; n++) begin
      if (!hold) begin
        rq   = $urandom_range(0, 3) != 0;
        we   = $urandom_range(0, 1) == 1;
        be   = 4'($urandom);
        addr = pick_addr();
        wd   = $urandom;
      end
      st = $urandom_range(0, 5) == 0;
      a_step(rq, we, be, addr, wd, st);
      hold = rq && !last_acc;
    end

    // instance a: continuous requests hit the in-flight limit
    for (int n = 0; n < 12; n++) begin
      if (n == 0 || last_acc) addr = BASE + 4 * $urandom_range(0, 15);
      a_step(1, 0, 4'hF, addr, 0, 0);
    end
    for (int n = 0; n < 5; n++) a_step(0, 0, 0, 0, 0, 0);

    // instance a: reset with a read in flight discards its response
    a_do(0, 4'hF, BASE, 0);
    a_step(0, 0, 0, 0, 0, 0);
    rst_ni = 0;
    a_req = 1;
    #1;
    chk("midrst_gnt", a_gnt, 0);
    chk("midrst_outst", a_outst, 0);
    chk("midrst_rvalid", a_rvalid, 0);
    q.delete();
    @(negedge clk);
    rst_ni = 1;
    cyc++;
    for (int n = 0; n < 6; n++) a_step(0, 0, 0, 0, 0, 0);
    a_do(0, 4'hF, BASE + 8, 0);
    for (int n = 0; n < 5; n++) a_step(0, 0, 0, 0, 0, 0);

    // instance b: grant delay and memory behaviour
    b_xfer(1, 32'h0010_0004, 4'hF, 32'hDEADBEEF, -1, 2, 32'h0, 0);
    b_xfer(0, 32'h0010_0004, 4'hF, 32'h0, -1, 2, 32'hDEADBEEF, 0);
    b_xfer(1, 32'h0010_0004, 4'b0010, 32'h0000AA00, 1, 3, 32'h0, 0);
    b_xfer(0, 32'h0010_0004, 4'hF, 32'h0, -1, 2, 32'hDEADAAEF, 0);
    b_xfer(1, 32'h0010_0000, 4'hF, 32'h12345678, -1, 2, 32'h0, 0);
    b_xfer(0, 32'h0010_1000, 4'hF, 32'h0, -1, 2, 32'h0, 1);
    b_xfer(1, 32'h0010_1000, 4'hF, 32'hFFFFFFFF, -1, 2, 32'h0, 1);
    b_xfer(1, 32'h000F_FFFC, 4'hF, 32'hFFFFFFFF, -1, 2, 32'h0, 1);
    b_xfer(1, 32'h0010_0000, 4'h0, 32'hFFFFFFFF, -1, 2, 32'h0, 0);
    b_xfer(0, 32'h0010_0003, 4'hF, 32'h0, -1, 2, 32'h12345678, 0);

    // instance b: req dropped while waiting restarts the delay
    b_req = 1; b_we = 0; b_addr = 32'h0010_0004;
    @(negedge clk);
    b_req = 0;
    @(negedge clk);
    b_xfer(0, 32'h0010_0004, 4'hF, 32'h0, -1, 2, 32'hDEADAAEF, 0);

    // instance b: held req gives accepts spaced GNT_DELAY+1 apart
    g = '{-1, -1, -1};
    ng = 0;
    b_req = 1; b_we = 0; b_addr = 32'h0010_0004;
    for (int c = 0; c < 9; c++) begin
      #1;
      if (b_gnt && ng < 3) begin
        g[ng] = c;
        ng++;
      end
      @(negedge clk);
    end
    b_req = 0;
    chk("b2b_gnt0", g[0], 2);
    chk("b2b_gnt1", g[1], 5);
    chk("b2b_gnt2", g[2], 8);
    @(negedge clk); @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
